// File: rtl/pio_wmem_master.sv
// Splits one wide application word into two 32-bit PIO accesses (LSB then MSB)
// against a wide-memory target, with ack handshaking and a per-access timeout.
module pio_wmem_master #(
    parameter int          WIDTH          = 50,
    parameter int          DEPTH_NBITS    = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   app_req,
    input  logic                   app_wr,
    input  logic [DEPTH_NBITS-1:0] app_addr,
    input  logic [WIDTH-1:0]       app_wdata,
    output logic                   app_busy,
    output logic                   app_done,
    output logic                   app_err,
    output logic [WIDTH-1:0]       app_rdata,
    output logic [31:0]            reg_addr,
    output logic [31:0]            reg_din,
    output logic                   reg_rd,
    output logic                   reg_wr,
    output logic                   reg_ms,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata
);

    localparam int PIO_NBITS = 32;
    localparam int HI_NBITS  = WIDTH - PIO_NBITS;
    localparam int CNT_NBITS = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_LOW
    } state_t;

    state_t state, state_d;
    logic   phase, phase_d;

    logic                   wr_q;
    logic [DEPTH_NBITS-1:0] addr_q;
    logic [WIDTH-1:0]       wdata_q;
    logic [PIO_NBITS-1:0]   lo_q;
    logic [CNT_NBITS-1:0]   cnt_q;
    logic                   ack_q;

    logic                   ack_edge;
    logic                   expired;
    logic                   accept;
    logic                   strobe;
    logic                   capture_lo;
    logic                   finish;
    logic                   fail;

    logic [31:0]            addr_off;
    logic [31:0]            hi_word;
    logic [31:0]            word_sel;

    assign app_busy = (state != IDLE);

    always_comb begin
        addr_off = '0;
        addr_off[DEPTH_NBITS+2:0] = {addr_q, phase, 2'b00};
        hi_word = '0;
        hi_word[HI_NBITS-1:0] = wdata_q[WIDTH-1:PIO_NBITS];
        word_sel = phase ? hi_word : wdata_q[PIO_NBITS-1:0];
    end

    always_comb begin
        ack_edge   = mem_ack & ~ack_q;
        expired    = (cnt_q == CNT_NBITS'(TIMEOUT_CYCLES - 1));
        state_d    = state;
        phase_d    = phase;
        accept     = 1'b0;
        strobe     = 1'b0;
        capture_lo = 1'b0;
        finish     = 1'b0;
        fail       = 1'b0;
        unique case (state)
            IDLE: begin
                if (app_req) begin
                    accept  = 1'b1;
                    phase_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_ack) begin
                    strobe  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // an ack edge wins over a simultaneous expiry
                if (ack_edge) begin
                    state_d    = WAIT_LOW;
                    capture_lo = ~phase;
                    finish     = phase;
                end else if (expired) begin
                    state_d = WAIT_LOW;
                    phase_d = 1'b1;
                    fail    = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!mem_ack) begin
                    if (phase) begin
                        state_d = IDLE;
                        phase_d = 1'b0;
                    end else begin
                        state_d = ISSUE;
                        phase_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= 1'b0;
            ack_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            ack_q <= mem_ack;
            if (strobe)
                cnt_q <= '0;
            else if (state == WAIT_ACK)
                cnt_q <= cnt_q + CNT_NBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            app_done  <= 1'b0;
            app_err   <= 1'b0;
            app_rdata <= '0;
            reg_addr  <= '0;
            reg_din   <= '0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_ms    <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= app_wr;
                addr_q  <= app_addr;
                wdata_q <= app_wdata;
            end
            reg_ms <= strobe;
            reg_rd <= strobe & ~wr_q;
            reg_wr <= strobe & wr_q;
            if (strobe) begin
                reg_addr <= BASE_ADDR | addr_off;
                reg_din  <= wr_q ? word_sel : 32'h0;
            end
            if (capture_lo)
                lo_q <= mem_rdata;
            app_done <= finish | fail;
            app_err  <= fail;
            if (finish && !wr_q)
                app_rdata <= {mem_rdata[HI_NBITS-1:0], lo_q};
        end
    end

endmodule

// File: tb/tb_pio_wmem_master.sv
// Directed bench for pio_wmem_master with a scripted PIO target model.
// Expected addresses, data and latencies are hand-computed constants.
module tb_pio_wmem_master;

    localparam int          WIDTH = 50;
    localparam int          DNB   = 10;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          TMO   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             app_req = 1'b0;
    logic             app_wr = 1'b0;
    logic [DNB-1:0]   app_addr = '0;
    logic [WIDTH-1:0] app_wdata = '0;
    logic             app_busy, app_done, app_err;
    logic [WIDTH-1:0] app_rdata;
    logic [31:0]      reg_addr, reg_din;
    logic             reg_rd, reg_wr, reg_ms;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic        resp_on = 1'b1;
    logic        msb_on = 1'b1;
    int          ack_dly = 4;
    int          ack_len = 1;
    logic [31:0] rd_lo = '0;
    logic [31:0] rd_hi = '0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int strobe_cyc = 0;
    int ms_cycles = 0;
    int bad_ack = 0;
    logic             last_err;
    logic [WIDTH-1:0] last_rdata;
    logic [31:0] s_addr[$];
    logic [31:0] s_din[$];
    logic        s_wr[$];
    logic        s_rd[$];

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = mem_ack ? (reg_addr[2] ? rd_hi : rd_lo) : 32'hDEAD_BEEF;

    pio_wmem_master #(
        .WIDTH(WIDTH),
        .DEPTH_NBITS(DNB),
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .app_req(app_req),
        .app_wr(app_wr),
        .app_addr(app_addr),
        .app_wdata(app_wdata),
        .app_busy(app_busy),
        .app_done(app_done),
        .app_err(app_err),
        .app_rdata(app_rdata),
        .reg_addr(reg_addr),
        .reg_din(reg_din),
        .reg_rd(reg_rd),
        .reg_wr(reg_wr),
        .reg_ms(reg_ms),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_ms) begin
            ms_cycles  = ms_cycles + 1;
            strobe_cyc = cyc;
            if (mem_ack) bad_ack = bad_ack + 1;
            s_addr.push_back(reg_addr);
            s_din.push_back(reg_din);
            s_wr.push_back(reg_wr);
            s_rd.push_back(reg_rd);
        end
        if (app_done) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            last_err   = app_err;
            last_rdata = app_rdata;
        end
    end

    // target: ack a strobe after ack_dly cycles, hold it ack_len cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reg_ms && resp_on && (!reg_addr[2] || msb_on)) begin
                repeat (ack_dly) begin
                    @(posedge clk);
                    #1;
                end
                resp_ack = 1'b1;
                repeat (ack_len) begin
                    @(posedge clk);
                    #1;
                end
                resp_ack = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        s_addr.delete();
        s_din.delete();
        s_wr.delete();
        s_rd.delete();
        ms_cycles = 0;
        bad_ack = 0;
    endtask

    task automatic start(input logic wr, input logic [DNB-1:0] a,
                         input logic [WIDTH-1:0] d);
        app_req   = 1'b1;
        app_wr    = wr;
        app_addr  = a;
        app_wdata = d;
        tick(1);
        app_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            tick(1);
            k++;
        end
        k = 0;
        while (app_busy && k < 100) begin
            tick(1);
            k++;
        end
        chk({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_idle"}, 64'(app_busy), 64'd0);
    endtask

    initial begin
        int d0;
        int k;

        tick(3);
        chk("rst_ctl", {58'd0, app_busy, app_done, app_err,
                        reg_rd, reg_wr, reg_ms}, 64'd0);
        chk("rst_rdata", 64'(app_rdata), 64'd0);
        chk("rst_addr", 64'(reg_addr), 64'd0);
        rst = 1'b0;
        tick(2);

        // write, ack after 4 cycles
        clear_log();
        d0 = done_cnt;
        start(1'b1, 10'd5, 50'h3_1234_5678_9ABC);
        chk("wr_busy", 64'(app_busy), 64'd1);
        wait_done("wr", d0);
        chk("wr_nstb", 64'(s_addr.size()), 64'd2);
        chk("wr_a0", 64'(s_addr[0]), 64'h0001_0028);
        chk("wr_d0", 64'(s_din[0]), 64'h5678_9ABC);
        chk("wr_a1", 64'(s_addr[1]), 64'h0001_002C);
        chk("wr_d1", 64'(s_din[1]), 64'h0003_1234);
        chk("wr_kind", {60'd0, s_wr[0], s_wr[1], s_rd[0], s_rd[1]}, 64'hC);
        chk("wr_err", 64'(last_err), 64'd0);
        chk("wr_rdata", 64'(app_rdata), 64'd0);
        chk("wr_mscyc", 64'(ms_cycles), 64'd2);

        // read of the top qword
        clear_log();
        rd_lo = 32'h89AB_CDEF;
        rd_hi = 32'h0002_FFFF;
        ack_dly = 2;
        d0 = done_cnt;
        start(1'b0, 10'h3FF, '0);
        wait_done("rd", d0);
        chk("rd_a0", 64'(s_addr[0]), 64'h0001_1FF8);
        chk("rd_a1", 64'(s_addr[1]), 64'h0001_1FFC);
        chk("rd_kind", {60'd0, s_wr[0], s_wr[1], s_rd[0], s_rd[1]}, 64'h3);
        chk("rd_data", 64'(last_rdata), 64'h2_FFFF_89AB_CDEF);
        chk("rd_err", 64'(last_err), 64'd0);

        // stretched ack
        clear_log();
        ack_dly = 1;
        ack_len = 8;
        d0 = done_cnt;
        start(1'b1, 10'd2, 50'h1_0000_0000_0001);
        wait_done("str", d0);
        chk("str_nstb", 64'(s_addr.size()), 64'd2);
        chk("str_mscyc", 64'(ms_cycles), 64'd2);
        chk("str_ackhi", 64'(bad_ack), 64'd0);
        chk("str_err", 64'(last_err), 64'd0);
        ack_len = 1;

        // timeout on a read: no ack at all
        clear_log();
        resp_on = 1'b0;
        d0 = done_cnt;
        start(1'b0, 10'd7, '0);
        wait_done("tmo", d0);
        chk("tmo_err", 64'(last_err), 64'd1);
        chk("tmo_lat", 64'(done_cyc - strobe_cyc), 64'd16);
        chk("tmo_nstb", 64'(s_addr.size()), 64'd1);
        chk("tmo_rdata", 64'(app_rdata), 64'h2_FFFF_89AB_CDEF);
        resp_on = 1'b1;

        // reset while waiting for the MSB ack
        clear_log();
        msb_on = 1'b0;
        d0 = done_cnt;
        start(1'b1, 10'd9, 50'h0_0000_1111_2222);
        k = 0;
        while (s_addr.size() < 2 && k < 100) begin
            tick(1);
            k++;
        end
        chk("ar_nstb", 64'(s_addr.size()), 64'd2);
        tick(2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_ctl", {58'd0, app_busy, app_done, app_err,
                       reg_rd, reg_wr, reg_ms}, 64'd0);
        chk("ar_out", {reg_addr, reg_din}, 64'd0);
        chk("ar_rdata", 64'(app_rdata), 64'd0);
        tick(2);
        rst = 1'b0;
        msb_on = 1'b1;
        tick(2);
        chk("ar_nodone", 64'(done_cnt - d0), 64'd0);
        clear_log();
        d0 = done_cnt;
        start(1'b1, 10'd1, 50'h0_0001_AAAA_5555);
        wait_done("ar2", d0);
        chk("ar2_a0", 64'(s_addr[0]), 64'h0001_0008);
        chk("ar2_d1", 64'(s_din[1]), 64'h0000_0001);
        chk("ar2_err", 64'(last_err), 64'd0);

        // ack already high at request time
        clear_log();
        force_ack = 1'b1;
        tick(1);
        d0 = done_cnt;
        start(1'b1, 10'd3, 50'h0_0000_0000_0042);
        tick(5);
        chk("pre_nstb", 64'(s_addr.size()), 64'd0);
        chk("pre_busy", 64'(app_busy), 64'd1);
        force_ack = 1'b0;
        wait_done("pre", d0);
        chk("pre_nstb2", 64'(s_addr.size()), 64'd2);
        chk("pre_a0", 64'(s_addr[0]), 64'h0001_0018);
        chk("pre_ackhi", 64'(bad_ack), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
